// File: rtl/mips_pkg.sv
// Shared widths and the memory-stage FSM encoding for the MIPS pipeline slice.
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_dmem_array.sv
// Word-addressed data memory: synchronous write, combinational read.
module dmem_array
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    // NOTE: the storage array has no reset; clearing every word would turn a RAM into a flop bank.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: wait-state data-memory access, branch resolution and MEM/WB register.
// Optional misalignment detection and sticky mem_fault output with `define ALIGN_CHECK_EN.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [WORD_W-1:0]     mem_b,
    input  logic [WORD_W-1:0]     mem_aluout,
    input  logic                  mem_zero,
    input  logic [WORD_W-1:0]     mem_add_result,
    input  logic                  mem_branch,
    input  logic                  mem_branch1,
    input  logic                  mem_memwrite,
    input  logic                  mem_memread,
    input  logic                  mem_memtoreg,
    input  logic                  mem_regwrite,
    output logic                  pcsrc,
    output logic [WORD_W-1:0]     branch_target,
    output logic                  stall,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [WORD_W-1:0]     wb_aluout,
    output logic [WORD_W-1:0]     wb_read_data,
    output logic                  wb_memtoreg,
    output logic                  wb_regwrite
`ifdef ALIGN_CHECK_EN
    ,
    output logic                  mem_fault
`endif
);

    localparam int            ADDR_W        = $clog2(DEPTH_WORDS);
    localparam logic          NO_WAIT       = (WAIT_CYCLES == 0);
    localparam logic [3:0]    WAIT_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    mem_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [WORD_W-1:0]     wb_aluout_q, wb_aluout_d;
    logic [WORD_W-1:0]     wb_read_data_q, wb_read_data_d;
    logic                  wb_memtoreg_q, wb_memtoreg_d;
    logic                  wb_regwrite_q, wb_regwrite_d;

    logic              mem_op;
    logic              ready;
    logic              complete;
    logic              misaligned;
    logic              dmem_we;
    logic [WORD_W-1:0] dmem_rdata;

    assign mem_op        = mem_memread | mem_memwrite;
    assign ready         = (state_q == MEM_WAIT && cnt_q == 4'd0) || NO_WAIT;
    assign stall         = mem_op & ~ready;
    assign complete      = mem_op & ready;
    assign pcsrc         = (mem_branch & mem_zero) | (mem_branch1 & ~mem_zero);
    assign branch_target = mem_add_result;

`ifdef ALIGN_CHECK_EN
    assign misaligned = (mem_aluout[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A reset edge must never commit the write of an access in flight.
    assign dmem_we = reset & complete & mem_memwrite & ~misaligned;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_dmem (
        .clk   (clk),
        .we    (dmem_we),
        .addr  (mem_aluout[ADDR_W+1:2]),
        .wdata (mem_b),
        .rdata (dmem_rdata)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MEM_IDLE: begin
                if (mem_op && !NO_WAIT) begin
                    state_d = MEM_WAIT;
                    cnt_d   = WAIT_CNT_INIT;
                end
            end
            MEM_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = MEM_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        wb_rd_d        = wb_rd_q;
        wb_aluout_d    = wb_aluout_q;
        wb_read_data_d = wb_read_data_q;
        wb_memtoreg_d  = 1'b0;
        wb_regwrite_d  = 1'b0;
        if (!stall) begin
            wb_rd_d        = mem_rd;
            wb_aluout_d    = mem_aluout;
            wb_memtoreg_d  = mem_memtoreg;
            wb_regwrite_d  = mem_regwrite & ~(mem_memread & misaligned);
            wb_read_data_d = (mem_memread && !mem_memwrite && !misaligned) ? dmem_rdata : '0;
        end
    end

`ifdef ALIGN_CHECK_EN
    logic fault_q, fault_d;
    assign fault_d   = fault_q | (complete & misaligned);
    assign mem_fault = fault_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= MEM_IDLE;
            cnt_q          <= 4'd0;
            wb_rd_q        <= '0;
            wb_aluout_q    <= '0;
            wb_read_data_q <= '0;
            wb_memtoreg_q  <= 1'b0;
            wb_regwrite_q  <= 1'b0;
`ifdef ALIGN_CHECK_EN
            fault_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wb_rd_q        <= wb_rd_d;
            wb_aluout_q    <= wb_aluout_d;
            wb_read_data_q <= wb_read_data_d;
            wb_memtoreg_q  <= wb_memtoreg_d;
            wb_regwrite_q  <= wb_regwrite_d;
`ifdef ALIGN_CHECK_EN
            fault_q        <= fault_d;
`endif
        end
    end

    assign wb_rd        = wb_rd_q;
    assign wb_aluout    = wb_aluout_q;
    assign wb_read_data = wb_read_data_q;
    assign wb_memtoreg  = wb_memtoreg_q;
    assign wb_regwrite  = wb_regwrite_q;

endmodule
